qpu_exu_trigger: RTL and testbench

Time-base and event-issue stage directly downstream of the execution-unit time/event queue. It owns the QPU's free-running experiment clock and presents it to the queue for head-of-queue comparison. It gates the queue's trigger and captures the events the queue releases, then drives registered per-channel event strobes to the qubit-control (QI) and measurement analog front ends. It also times a measurement window per measurement channel, so that a stop request drains cleanly.

---
 rtl/qpu_exu_trigger_pkg.sv | 23 ++
 rtl/qpu_exu_trigger_meas_win.sv | 69 ++++++
 rtl/qpu_exu_trigger.sv | 165 ++++++++++++++++
 tb/tb_qpu_exu_trigger.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_trigger_pkg.sv
// ---------------------------------------------------------------------------
// qpu_exu_trigger_pkg
// Shared constants for the QPU execution-unit trigger stage:
//   - default time-counter width, channel counts and payload widths
//   - default measurement window length
//   - trigger FSM state encoding (IDLE=0, RUN=1, DRAIN=2)
// ---------------------------------------------------------------------------
package qpu_exu_trigger_pkg;

    localparam int unsigned QPU_TIME_WIDTH          = 16;
    localparam int unsigned QPU_QI_EVENT_NUM        = 8;
    localparam int unsigned QPU_MEASURE_EVENT_NUM   = 2;
    localparam int unsigned QPU_QI_EVENT_WIDTH      = 10;
    localparam int unsigned QPU_MEASURE_EVENT_WIDTH = 8;
    localparam int unsigned QPU_TRIGGER_MEAS_WIN    = 64;

    typedef enum logic [1:0] {
        QPU_TRG_IDLE  = 2'd0,
        QPU_TRG_RUN   = 2'd1,
        QPU_TRG_DRAIN = 2'd2
    } qpu_trg_state_e;

endpackage

// File: rtl/qpu_exu_trigger_meas_win.sv
// ---------------------------------------------------------------------------
// qpu_exu_trigger_meas_win
// One measurement-window timer. A load starts (or restarts) a window of
// MEAS_WIN cycles; busy_o is high for exactly MEAS_WIN cycles beginning the
// cycle after the load. A load while busy sets the sticky collide flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : measurement event accepted this cycle
//   clr_i      : clear the sticky collide flag (start of experiment)
//   busy_o     : window active
//   collide_o  : sticky, event arrived while the window was active
// ---------------------------------------------------------------------------
module qpu_exu_trigger_meas_win #(
    parameter int unsigned MEAS_WIN = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clr_i,
    output logic busy_o,
    output logic collide_o
);

    localparam int unsigned CW = $clog2(MEAS_WIN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          col_q, col_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        col_d  = col_q;
        if (load_i) begin
            cnt_d  = CW'(MEAS_WIN - 1);
            busy_d = 1'b1;
            if (busy_q) begin
                col_d = 1'b1;
            end
        end else if (busy_q) begin
            // busy drops on the edge after the counter has shown 0, which
            // makes the window MEAS_WIN cycles long (MEAS_WIN-1 .. 0)
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        if (clr_i) begin
            col_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            col_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            col_q  <= col_d;
        end
    end

    assign busy_o    = busy_q;
    assign collide_o = col_q;

endmodule

// File: rtl/qpu_exu_trigger.sv
// ---------------------------------------------------------------------------
// qpu_exu_trigger
// Time-base and event-issue stage after the EXU time/event queue. Owns the
// experiment time counter, gates the queue trigger, captures released events
// into registered per-channel strobes/payloads for the QI and measurement
// front ends, and (optionally) times a measurement window per channel so a
// stop request drains cleanly.
// Build option: define QPU_TRIGGER_MEAS_WIN_EN to build the measurement
// window timers; otherwise meas_o_busy/o_collide are 0 and DRAIN lasts one
// cycle.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   i_start, i_stop       : experiment start / stop request pulses
//   o_tragger             : trigger to the queue, high in RUN
//   i_clk_ena             : time-advance permission from the queue
//   o_clk                 : experiment time
//   evq_i_valid/evq_i_data: per-channel events (QI channels low)
//   qi_o_valid/qi_o_data  : QI strobes and held payloads
//   meas_o_valid/meas_o_data : measurement strobes and held payloads
//   meas_o_busy, o_collide: measurement window status, sticky collision
//   o_wrap                : sticky time-counter wrap
//   o_state               : FSM state
// ---------------------------------------------------------------------------
module qpu_exu_trigger
    import qpu_exu_trigger_pkg::*;
#(
    parameter int unsigned TIME_WIDTH = QPU_TIME_WIDTH,
    parameter int unsigned QI_NUM     = QPU_QI_EVENT_NUM,
    parameter int unsigned MEAS_NUM   = QPU_MEASURE_EVENT_NUM,
    parameter int unsigned QI_W       = QPU_QI_EVENT_WIDTH,
    parameter int unsigned MEAS_W     = QPU_MEASURE_EVENT_WIDTH,
    parameter int unsigned MEAS_WIN   = QPU_TRIGGER_MEAS_WIN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    output logic                         o_tragger,
    input  logic                         i_clk_ena,
    output logic [TIME_WIDTH-1:0]        o_clk,
    input  logic [QI_NUM+MEAS_NUM-1:0]   evq_i_valid,
    input  logic [QI_NUM*QI_W+MEAS_NUM*MEAS_W-1:0] evq_i_data,
    output logic [QI_NUM-1:0]            qi_o_valid,
    output logic [QI_NUM*QI_W-1:0]       qi_o_data,
    output logic [MEAS_NUM-1:0]          meas_o_valid,
    output logic [MEAS_NUM*MEAS_W-1:0]   meas_o_data,
    output logic [MEAS_NUM-1:0]          meas_o_busy,
    output logic [MEAS_NUM-1:0]          o_collide,
    output logic                         o_wrap,
    output logic [1:0]                   o_state
);

    localparam int unsigned EVN  = QI_NUM + MEAS_NUM;
    localparam int unsigned QIWT = QI_NUM * QI_W;

    if (MEAS_WIN < 2) begin : g_bad_win
        $error("MEAS_WIN must be at least 2");
    end

    qpu_trg_state_e              state_q, state_d;
    logic                        trg_q;
    logic [TIME_WIDTH-1:0]       time_q, time_d;
    logic                        wrap_q, wrap_d;
    logic [QI_NUM-1:0]           qi_valid_q;
    logic [QIWT-1:0]             qi_data_q, qi_data_d;
    logic [MEAS_NUM-1:0]         meas_valid_q;
    logic [MEAS_NUM*MEAS_W-1:0]  meas_data_q, meas_data_d;
    logic                        run;
    logic                        start_run;
    logic [EVN-1:0]              cap;

    assign run       = (state_q == QPU_TRG_RUN);
    assign start_run = (state_q == QPU_TRG_IDLE) && i_start;
    assign cap       = evq_i_valid & {EVN{run}};

    // next state; stop takes priority because RUN only looks at i_stop
    always_comb begin
        state_d = state_q;
        case (state_q)
            QPU_TRG_IDLE:  if (i_start)          state_d = QPU_TRG_RUN;
            QPU_TRG_RUN:   if (i_stop)           state_d = QPU_TRG_DRAIN;
            QPU_TRG_DRAIN: if (meas_o_busy == '0) state_d = QPU_TRG_IDLE;
            default:                             state_d = QPU_TRG_IDLE;
        endcase
    end

    always_comb begin
        time_d = time_q;
        wrap_d = wrap_q;
        if (start_run) begin
            time_d = '0;
            wrap_d = 1'b0;
        end else if (run && i_clk_ena) begin
            time_d = time_q + TIME_WIDTH'(1);
            if (&time_q) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_comb begin
        qi_data_d   = qi_data_q;
        meas_data_d = meas_data_q;
        for (int unsigned i = 0; i < QI_NUM; i++) begin
            if (cap[i]) begin
                qi_data_d[i*QI_W +: QI_W] = evq_i_data[i*QI_W +: QI_W];
            end
        end
        for (int unsigned j = 0; j < MEAS_NUM; j++) begin
            if (cap[QI_NUM+j]) begin
                meas_data_d[j*MEAS_W +: MEAS_W] = evq_i_data[QIWT + j*MEAS_W +: MEAS_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= QPU_TRG_IDLE;
            trg_q        <= 1'b0;
            time_q       <= '0;
            wrap_q       <= 1'b0;
            qi_valid_q   <= '0;
            qi_data_q    <= '0;
            meas_valid_q <= '0;
            meas_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            trg_q        <= (state_d == QPU_TRG_RUN);
            time_q       <= time_d;
            wrap_q       <= wrap_d;
            qi_valid_q   <= cap[QI_NUM-1:0];
            qi_data_q    <= qi_data_d;
            meas_valid_q <= cap[EVN-1:QI_NUM];
            meas_data_q  <= meas_data_d;
        end
    end

`ifdef QPU_TRIGGER_MEAS_WIN_EN
    for (genvar g = 0; g < MEAS_NUM; g++) begin : g_win
        qpu_exu_trigger_meas_win #(
            .MEAS_WIN (MEAS_WIN)
        ) u_win (
            .clk       (clk),
            .rst       (rst),
            .load_i    (cap[QI_NUM+g]),
            .clr_i     (start_run),
            .busy_o    (meas_o_busy[g]),
            .collide_o (o_collide[g])
        );
    end
`else
    assign meas_o_busy = '0;
    assign o_collide   = '0;
`endif

    assign o_tragger    = trg_q;
    assign o_clk        = time_q;
    assign o_wrap       = wrap_q;
    assign o_state      = state_q;
    assign qi_o_valid   = qi_valid_q;
    assign qi_o_data    = qi_data_q;
    assign meas_o_valid = meas_valid_q;
    assign meas_o_data  = meas_data_q;

endmodule

// File: tb/tb_qpu_exu_trigger.sv
module tb_qpu_exu_trigger;

    localparam int TW  = 8;
    localparam int QN  = 8;
    localparam int MN  = 2;
    localparam int QW  = 10;
    localparam int MW  = 8;
    localparam int WIN = 64;
    localparam int EVN = QN + MN;
    localparam int WW  = QN*QW + MN*MW;
`ifdef QPU_TRIGGER_MEAS_WIN_EN
    localparam bit MW_EN = 1'b1;
`else
    localparam bit MW_EN = 1'b0;
`endif

    logic              clk, rst, i_start, i_stop, i_clk_ena;
    logic [EVN-1:0]    evq_i_valid;
    logic [WW-1:0]     evq_i_data;
    logic              o_tragger, o_wrap;
    logic [TW-1:0]     o_clk;
    logic [QN-1:0]     qi_o_valid;
    logic [QN*QW-1:0]  qi_o_data;
    logic [MN-1:0]     meas_o_valid, meas_o_busy, o_collide;
    logic [MN*MW-1:0]  meas_o_data;
    logic [1:0]        o_state;

    qpu_exu_trigger #(
        .TIME_WIDTH (TW), .QI_NUM (QN), .MEAS_NUM (MN),
        .QI_W (QW), .MEAS_W (MW), .MEAS_WIN (WIN)
    ) dut (
        .clk (clk), .rst (rst), .i_start (i_start), .i_stop (i_stop),
        .o_tragger (o_tragger), .i_clk_ena (i_clk_ena), .o_clk (o_clk),
        .evq_i_valid (evq_i_valid), .evq_i_data (evq_i_data),
        .qi_o_valid (qi_o_valid), .qi_o_data (qi_o_data),
        .meas_o_valid (meas_o_valid), .meas_o_data (meas_o_data),
        .meas_o_busy (meas_o_busy), .o_collide (o_collide),
        .o_wrap (o_wrap), .o_state (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: state as integer, windows as absolute end cycles
    int          m_state;
    logic [TW-1:0] m_time;
    logic        m_wrap;
    logic [QN-1:0] m_qv;
    logic [MN-1:0] m_mv;
    logic [QW-1:0] m_qd [QN];
    logic [MW-1:0] m_md [MN];
    longint      m_bend [MN];
    logic [MN-1:0] m_col;
    longint      cyc;

    function automatic bit m_busy(int k);
        return MW_EN && (cyc < m_bend[k]);
    endfunction

    task automatic model_reset();
        m_state = 0; m_time = '0; m_wrap = 1'b0; m_qv = '0; m_mv = '0; m_col = '0;
        cyc = 0;
        for (int k = 0; k < QN; k++) m_qd[k] = '0;
        for (int k = 0; k < MN; k++) begin m_md[k] = '0; m_bend[k] = 0; end
    endtask

    task automatic model_edge();
        bit run, start, busy_any;
        run = (m_state == 1);
        start = (m_state == 0) && i_start;
        busy_any = 1'b0;
        for (int k = 0; k < MN; k++) if (m_busy(k)) busy_any = 1'b1;
        m_qv = '0;
        m_mv = '0;
        if (run) begin
            for (int k = 0; k < QN; k++)
                if (evq_i_valid[k]) begin m_qv[k] = 1'b1; m_qd[k] = evq_i_data[k*QW +: QW]; end
            for (int k = 0; k < MN; k++)
                if (evq_i_valid[QN+k]) begin
                    m_mv[k] = 1'b1;
                    m_md[k] = evq_i_data[QN*QW + k*MW +: MW];
                    if (m_busy(k)) m_col[k] = 1'b1;
                    m_bend[k] = cyc + 1 + WIN;
                end
        end
        if (start) begin
            m_time = '0; m_wrap = 1'b0; m_col = '0;
        end else if (run && i_clk_ena) begin
            if (m_time == {TW{1'b1}}) m_wrap = 1'b1;
            m_time = m_time + 1'b1;
        end
        case (m_state)
            0: if (i_start) m_state = 1;
            1: if (i_stop) m_state = 2;
            default: if (!busy_any) m_state = 0;
        endcase
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; i_start = 0; i_stop = 0; i_clk_ena = 0; evq_i_valid = '0; evq_i_data = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        checks++; if (o_tragger !== 1'b0) begin errors++; $display("FAIL reset_trg: got %b expected 0", o_tragger); end
        checks++; if (o_clk !== '0) begin errors++; $display("FAIL reset_clk: got %h expected 0", o_clk); end
        checks++; if (o_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", o_wrap); end
        checks++; if (qi_o_valid !== '0 || meas_o_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h/%h expected 0", qi_o_valid, meas_o_valid); end
        checks++; if (qi_o_data !== '0 || meas_o_data !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0", qi_o_data, meas_o_data); end
        checks++; if (meas_o_busy !== '0 || o_collide !== '0) begin errors++; $display("FAIL reset_meas: got busy %b col %b expected 0", meas_o_busy, o_collide); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_start_count();
        i_start = 1'b1; tick(); i_start = 1'b0;
        checks++; if (o_tragger !== 1'b1) begin errors++; $display("FAIL start_trg: got %b expected 1", o_tragger); end
        checks++; if (o_state !== 2'd1 || o_clk !== '0) begin errors++; $display("FAIL start_state: got %0d clk %0d expected 1 clk 0", o_state, o_clk); end
        i_clk_ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (o_clk !== TW'(i+1) || o_clk !== m_time) begin errors++; $display("FAIL count_clk: got %0d expected %0d", o_clk, i+1); end
        end
    endtask

    task automatic test_stall();
        logic [TW-1:0] held;
        held = o_clk;
        i_clk_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_clk !== held || o_tragger !== 1'b1) begin errors++; $display("FAIL stall: got clk %0d trg %b expected %0d 1", o_clk, o_tragger, held); end
        end
    endtask

    task automatic test_qi_events();
        evq_i_data = {$urandom, $urandom, $urandom};
        evq_i_data[0 +: QW] = 10'h155;
        evq_i_data[2*QW +: QW] = 10'h0AA;
        evq_i_valid = 10'b0000000101;
        tick();
        evq_i_valid = '0;
        evq_i_data = {$urandom, $urandom, $urandom};
        checks++; if (qi_o_valid !== 8'b00000101 || meas_o_valid !== '0) begin errors++; $display("FAIL qi_strobe: got %b expected 00000101", qi_o_valid); end
        checks++; if (qi_o_data[0 +: QW] !== 10'h155 || qi_o_data[2*QW +: QW] !== 10'h0AA) begin errors++; $display("FAIL qi_data: got %h %h expected 155 0aa", qi_o_data[0 +: QW], qi_o_data[2*QW +: QW]); end
        tick();
        checks++; if (qi_o_valid !== '0) begin errors++; $display("FAIL qi_strobe_len: got %b expected 0", qi_o_valid); end
        checks++; if (qi_o_data[0 +: QW] !== 10'h155 || qi_o_data[2*QW +: QW] !== 10'h0AA) begin errors++; $display("FAIL qi_hold: got %h %h expected 155 0aa", qi_o_data[0 +: QW], qi_o_data[2*QW +: QW]); end
        for (int i = 0; i < 30; i++) begin
            evq_i_valid = EVN'($urandom & {QN{1'b1}});
            evq_i_data = {$urandom, $urandom, $urandom};
            tick();
            checks++; if (qi_o_valid !== m_qv) begin errors++; $display("FAIL qi_rand_valid: got %b expected %b", qi_o_valid, m_qv); end
            for (int k = 0; k < QN; k++) begin
                checks++; if (qi_o_data[k*QW +: QW] !== m_qd[k]) begin errors++; $display("FAIL qi_rand_data%0d: got %h expected %h", k, qi_o_data[k*QW +: QW], m_qd[k]); end
            end
        end
        evq_i_valid = '0;
    endtask

    task automatic test_meas_window();
        int busy_cnt, drain_cnt, n;
        busy_cnt = 0; drain_cnt = 0;
        evq_i_valid = '0; evq_i_valid[QN] = 1'b1;
        evq_i_data[QN*QW +: MW] = 8'hC3;
        tick();
        evq_i_valid = '0;
        checks++; if (meas_o_valid !== 2'b01 || meas_o_data[0 +: MW] !== 8'hC3) begin errors++; $display("FAIL meas_strobe: got %b %h expected 01 c3", meas_o_valid, meas_o_data[0 +: MW]); end
        if (meas_o_busy[0]) busy_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (meas_o_busy[0]) busy_cnt++;
        end
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        if (meas_o_busy[0]) busy_cnt++;
        checks++; if (o_state !== 2'd2 || o_tragger !== 1'b0) begin errors++; $display("FAIL stop_drain: got state %0d trg %b expected 2 0", o_state, o_tragger); end
        n = 0;
        while (o_state == 2'd2 && n < 300) begin
            drain_cnt++;
            tick();
            n++;
            if (meas_o_busy[0]) busy_cnt++;
            checks++; if (o_state !== 2'(m_state) || meas_o_busy[0] !== m_busy(0)) begin errors++; $display("FAIL drain_step: got state %0d busy %b expected %0d %b", o_state, meas_o_busy[0], m_state, m_busy(0)); end
        end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL drain_timeout: got state %0d expected 0", o_state); end
        checks++; if (busy_cnt != (MW_EN ? WIN : 0)) begin errors++; $display("FAIL busy_len: got %0d expected %0d", busy_cnt, MW_EN ? WIN : 0); end
        checks++; if (drain_cnt != (MW_EN ? WIN - 10 : 1)) begin errors++; $display("FAIL drain_len: got %0d expected %0d", drain_cnt, MW_EN ? WIN - 10 : 1); end
    endtask

    task automatic test_collide();
        int busy_cnt, n;
        i_start = 1'b1; tick(); i_start = 1'b0;
        evq_i_valid = '0; evq_i_valid[QN] = 1'b1; tick(); evq_i_valid = '0;
        for (int i = 0; i < 19; i++) tick();
        checks++; if (meas_o_busy[0] !== MW_EN || o_collide !== '0) begin errors++; $display("FAIL pre_collide: got busy %b col %b expected %b 00", meas_o_busy[0], o_collide, MW_EN); end
        evq_i_valid[QN] = 1'b1; tick(); evq_i_valid = '0;
        checks++; if (o_collide !== {1'b0, MW_EN} || meas_o_valid !== 2'b01) begin errors++; $display("FAIL collide: got col %b strobe %b expected %b 01", o_collide, meas_o_valid, {1'b0, MW_EN}); end
        busy_cnt = 0; n = 0;
        while (meas_o_busy[0] && n < 300) begin busy_cnt++; tick(); n++; end
        checks++; if (busy_cnt != (MW_EN ? WIN : 0)) begin errors++; $display("FAIL collide_busy_len: got %0d expected %0d", busy_cnt, MW_EN ? WIN : 0); end
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        n = 0;
        while (o_state != 2'd0 && n < 300) begin tick(); n++; end
        checks++; if (o_state !== 2'd0 || o_collide !== {1'b0, MW_EN}) begin errors++; $display("FAIL collide_sticky: got state %0d col %b expected 0 %b", o_state, o_collide, {1'b0, MW_EN}); end
        i_start = 1'b1; tick(); i_start = 1'b0;
        checks++; if (o_collide !== '0 || o_state !== 2'd1) begin errors++; $display("FAIL collide_clear: got col %b state %0d expected 00 1", o_collide, o_state); end
    endtask

    task automatic test_wrap_and_async_reset();
        int n;
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        n = 0;
        while (o_state != 2'd0 && n < 300) begin tick(); n++; end
        i_start = 1'b1; tick(); i_start = 1'b0;
        i_clk_ena = 1'b1;
        for (int i = 0; i < (1 << TW) - 1; i++) tick();
        checks++; if (o_clk !== {TW{1'b1}} || o_wrap !== 1'b0) begin errors++; $display("FAIL pre_wrap: got %h wrap %b expected ff 0", o_clk, o_wrap); end
        tick();
        checks++; if (o_clk !== '0 || o_wrap !== 1'b1) begin errors++; $display("FAIL wrap: got %h wrap %b expected 0 1", o_clk, o_wrap); end
        tick();
        checks++; if (o_clk !== TW'(1) || o_wrap !== 1'b1) begin errors++; $display("FAIL wrap_sticky: got %h wrap %b expected 1 1", o_clk, o_wrap); end
        evq_i_valid = '1; evq_i_data = {$urandom, $urandom, $urandom};
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (o_state !== 2'd0 || o_tragger !== 1'b0 || o_clk !== '0 || o_wrap !== 1'b0) begin errors++; $display("FAIL async_rst_ctl: got st %0d trg %b clk %h wrap %b expected 0", o_state, o_tragger, o_clk, o_wrap); end
        checks++; if (qi_o_valid !== '0 || meas_o_valid !== '0 || qi_o_data !== '0 || meas_o_data !== '0) begin errors++; $display("FAIL async_rst_ev: got %h %h expected 0", qi_o_valid, meas_o_valid); end
        checks++; if (meas_o_busy !== '0 || o_collide !== '0) begin errors++; $display("FAIL async_rst_meas: got %b %b expected 0", meas_o_busy, o_collide); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        checks++; if (qi_o_valid !== '0 || meas_o_valid !== '0 || o_state !== 2'd0) begin errors++; $display("FAIL post_rst_strobe: got %h %h st %0d expected 0", qi_o_valid, meas_o_valid, o_state); end
        evq_i_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic [MN-1:0] eb;
        for (int i = 0; i < 600; i++) begin
            i_start = ($urandom_range(0, 7) == 0);
            i_stop = ($urandom_range(0, 23) == 0);
            i_clk_ena = $urandom_range(0, 1);
            evq_i_valid = EVN'($urandom & $urandom);
            evq_i_data = {$urandom, $urandom, $urandom};
            tick();
            for (int k = 0; k < MN; k++) eb[k] = m_busy(k);
            checks++; if (o_state !== 2'(m_state) || o_tragger !== (m_state == 1)) begin errors++; $display("FAIL b2b_state: got %0d trg %b expected %0d", o_state, o_tragger, m_state); end
            checks++; if (o_clk !== m_time || o_wrap !== m_wrap) begin errors++; $display("FAIL b2b_time: got %h %b expected %h %b", o_clk, o_wrap, m_time, m_wrap); end
            checks++; if (qi_o_valid !== m_qv || meas_o_valid !== m_mv) begin errors++; $display("FAIL b2b_valid: got %b %b expected %b %b", qi_o_valid, meas_o_valid, m_qv, m_mv); end
            checks++; if (meas_o_busy !== eb || o_collide !== m_col) begin errors++; $display("FAIL b2b_meas: got busy %b col %b expected %b %b", meas_o_busy, o_collide, eb, m_col); end
            for (int k = 0; k < QN; k++) begin
                checks++; if (qi_o_data[k*QW +: QW] !== m_qd[k]) begin errors++; $display("FAIL b2b_qi_data%0d: got %h expected %h", k, qi_o_data[k*QW +: QW], m_qd[k]); end
            end
            for (int k = 0; k < MN; k++) begin
                checks++; if (meas_o_data[k*MW +: MW] !== m_md[k]) begin errors++; $display("FAIL b2b_meas_data%0d: got %h expected %h", k, meas_o_data[k*MW +: MW], m_md[k]); end
            end
        end
        i_start = 0; i_stop = 0; evq_i_valid = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_count();
        test_stall();
        test_qi_events();
        test_meas_window();
        test_collide();
        test_wrap_and_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
